// File: rtl/debounce_sync.sv
// -----------------------------------------------------------------------------
// debounce_sync
//
// Turns one raw, bouncing, asynchronous push-button/switch input into a clean
// clock-synchronous level, plus single-cycle rise/fall strobes and a counter
// of accepted rising edges.
//
// The raw input passes through a two-flop synchronizer. A four-state FSM then
// accepts a new value only after it has been seen for STABLE_CYCLES
// consecutive synchronized samples. Any reversion during qualification sends
// the FSM back to its stable state, so qualification restarts from zero.
//
// Parameters:
//   STABLE_CYCLES  consecutive synchronized samples needed to accept a value
//                  (legal range 2 .. 2**CNT_W-1)
//   CNT_W          width of the stability counter
//   EVT_W          width of evt_count
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_in     in   raw asynchronous input
//   level      out  registered debounced level
//   rise       out  one-cycle strobe when level goes 0->1
//   fall       out  one-cycle strobe when level goes 1->0
//   evt_count  out  accepted rising edges, modulo 2**EVT_W
// -----------------------------------------------------------------------------
module debounce_sync #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20,
    parameter int EVT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [EVT_W-1:0] evt_count
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    // The sample that enters a WAIT state already counts as the first one,
    // so acceptance happens when the count of earlier samples reaches
    // STABLE_CYCLES-1 and the current sample still agrees.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync_out;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync_out  <= 1'b0;
            state     <= STABLE_LO;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            evt_count <= '0;
        end else begin
            // Two-flop synchronizer; only sync_out is used by the FSM.
            sync1    <= btn_in;
            sync_out <= sync1;

            // Strobes are single-cycle: cleared unless an acceptance sets them.
            rise <= 1'b0;
            fall <= 1'b0;

            case (state)
                STABLE_LO: begin
                    if (sync_out) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end

                WAIT_HI: begin
                    if (!sync_out) begin
                        // Glitch rejected, no strobe.
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= STABLE_HI;
                        cnt       <= '0;
                        level     <= 1'b1;
                        rise      <= 1'b1;
                        evt_count <= evt_count + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STABLE_HI: begin
                    if (!sync_out) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end

                WAIT_LO: begin
                    if (sync_out) begin
                        // Glitch rejected, no strobe.
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    // Recovery from a corrupted state register.
                    state <= STABLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_debounce_sync
//
// Directed bench for debounce_sync with STABLE_CYCLES=4, CNT_W=3, EVT_W=4.
// A behavioural model counts consecutive synchronized samples that disagree
// with the current debounced level and accepts the new value when that run
// reaches STABLE_CYCLES. A compare process checks the DUT against the model
// and the strobe/level invariants on every falling clock edge, and the
// directed sequence adds literal expectations at known cycle offsets.
// -----------------------------------------------------------------------------
module tb_debounce_sync;

    localparam int SC = 4;
    localparam int CW = 3;
    localparam int EW = 4;

    logic          clk;
    logic          rst_n;
    logic          btn_in;
    logic          level;
    logic          rise;
    logic          fall;
    logic [EW-1:0] evt_count;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    debounce_sync #(
        .STABLE_CYCLES(SC),
        .CNT_W        (CW),
        .EVT_W        (EW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .level    (level),
        .rise     (rise),
        .fall     (fall),
        .evt_count(evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_s1, m_s2, m_level, m_rise, m_fall, m_run, m_evt;

    always @(posedge clk or negedge rst_n) begin
        int sampled;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_rise = 0; m_fall = 0;
            m_run = 0; m_evt = 0;
        end else begin
            sampled = m_s2;          // value the FSM sees this edge
            m_s2    = m_s1;
            m_s1    = (btn_in === 1'b1) ? 1 : 0;
            m_rise  = 0;
            m_fall  = 0;
            if (sampled != m_level) begin
                m_run++;
                if (m_run == SC) begin
                    m_level = sampled;
                    m_run   = 0;
                    if (sampled == 1) begin
                        m_rise = 1;
                        m_evt  = (m_evt + 1) % (1 << EW);
                    end else begin
                        m_fall = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic prev_level = 1'b0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        chk("model_level", {31'd0, level}, m_level);
        chk("model_rise",  {31'd0, rise},  m_rise);
        chk("model_fall",  {31'd0, fall},  m_fall);
        chk("model_evt",   {28'd0, evt_count}, m_evt);
        chk("inv_not_both", {31'd0, rise & fall}, 0);
        if (rst_n && prev_valid) begin
            chk("inv_rise_edge", {31'd0, rise}, {31'd0, level & ~prev_level});
            chk("inv_fall_edge", {31'd0, fall}, {31'd0, ~level & prev_level});
        end
        if (rise === 1'b1) rise_cnt++;
        if (fall === 1'b1) fall_cnt++;
        prev_level = level;
        prev_valid = rst_n;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int r0, f0;

    initial begin
        rst_n  = 1'b1;
        btn_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        // Reset takes effect without any clock edge.
        chk("rst_async_level", {31'd0, level}, 0);
        chk("rst_async_rise",  {31'd0, rise},  0);
        chk("rst_async_fall",  {31'd0, fall},  0);
        chk("rst_async_evt",   {28'd0, evt_count}, 0);

        // Release reset with btn_in held high: normal accept follows.
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("rel_rise_early",  {31'd0, rise},  0);
        chk("rel_level_early", {31'd0, level}, 0);
        step();
        chk("rel_rise",  {31'd0, rise},  1);
        chk("rel_level", {31'd0, level}, 1);
        chk("rel_evt",   {28'd0, evt_count}, 1);
        step();
        chk("rel_rise_off", {31'd0, rise}, 0);

        // Clean release.
        btn_in = 1'b0;
        repeat (5) step();
        chk("fall_early", {31'd0, fall}, 0);
        step();
        chk("fall_pulse", {31'd0, fall},  1);
        chk("fall_level", {31'd0, level}, 0);
        chk("fall_evt",   {28'd0, evt_count}, 1);
        step();
        chk("fall_off", {31'd0, fall}, 0);

        // Clean press.
        btn_in = 1'b1;
        repeat (6) step();
        chk("press_rise", {31'd0, rise}, 1);
        chk("press_evt",  {28'd0, evt_count}, 2);
        step();
        chk("press_rise_off", {31'd0, rise}, 0);
        btn_in = 1'b0;
        repeat (8) step();
        chk("press_rel_level", {31'd0, level}, 0);

        // Bounce 1,0,1,0 (2 cycles each), then settle high.
        r0 = rise_cnt;
        for (int k = 0; k < 4; k++) begin
            btn_in = (k % 2 == 0);
            repeat (2) step();
        end
        btn_in = 1'b1;
        repeat (5) step();
        chk("bounce_rise_early", {31'd0, rise},  0);
        chk("bounce_level_early", {31'd0, level}, 0);
        step();
        chk("bounce_rise", {31'd0, rise}, 1);
        chk("bounce_evt",  {28'd0, evt_count}, 3);
        repeat (4) step();
        chk("bounce_one_rise", rise_cnt - r0, 1);
        btn_in = 1'b0;
        repeat (8) step();

        // Three-cycle glitch is rejected.
        r0 = rise_cnt;
        f0 = fall_cnt;
        btn_in = 1'b1;
        repeat (3) step();
        btn_in = 1'b0;
        repeat (10) step();
        chk("glitch_level", {31'd0, level}, 0);
        chk("glitch_rises", rise_cnt - r0, 0);
        chk("glitch_falls", fall_cnt - f0, 0);
        chk("glitch_evt",   {28'd0, evt_count}, 3);

        // Presses until evt_count wraps 15 -> 0.
        for (int i = 0; i < 13; i++) begin
            btn_in = 1'b1;
            repeat (6) step();
            chk("wrap_rise", {31'd0, rise}, 1);
            chk("wrap_evt",  {28'd0, evt_count}, (4 + i) % 16);
            step();
            btn_in = 1'b0;
            repeat (8) step();
        end
        chk("wrap_final_evt",   {28'd0, evt_count}, 0);
        chk("wrap_final_level", {31'd0, level}, 0);

        // Reset during WAIT_HI with cnt=2.
        btn_in = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_level", {31'd0, level}, 0);
        chk("midrst_rise",  {31'd0, rise},  0);
        chk("midrst_evt",   {28'd0, evt_count}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("midrst_rise_early", {31'd0, rise}, 0);
        step();
        chk("midrst_rise_after", {31'd0, rise}, 1);
        chk("midrst_evt_after",  {28'd0, evt_count}, 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
